// File: rtl/i2c_target_pkg.sv
`default_nettype none
// ============================================================================
// i2c_target_pkg : shared state encoding and constants for the I2C target
// Rev 1.0
// ============================================================================
package i2c_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } i2c_tgt_state_t;

    localparam logic I2C_READ = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// i2c_line_filter : 2-FF synchronizer, glitch filter and edge strobes
// Rev 1.0
// ============================================================================
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // The level only moves after FILTER_LEN consecutive samples disagree with it;
    // the edge strobes rise in the same cycle the new level becomes visible.
    always_comb begin
        sync1_d = line_i;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target_responder.sv
`default_nettype none
// ============================================================================
// i2c_target_responder : fixed-address I2C target with write/read byte streams
// Rev 1.0
// ============================================================================
module i2c_target_responder
    import i2c_target_pkg::*;
#(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h22,
    parameter int                        FILTER_LEN     = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      wr_valid_o,
    input  logic                      wr_ready_i,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
    input  logic                      rd_valid_i,
    output logic                      rd_ready_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      busy_o
);

    localparam int                 BCW      = $clog2(I2C_DATA_WIDTH);
    localparam logic [BCW-1:0]     LAST_BIT = BCW'(I2C_DATA_WIDTH - 1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .line_i  (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .line_i  (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    i2c_tgt_state_t            state_q, state_d;
    logic [I2C_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic                      rw_q, rw_d;
    logic                      ack_phase_q, ack_phase_d;
    logic                      need_byte_q, need_byte_d;
    logic                      sda_q, sda_d;
    logic                      scl_q, scl_d;
    logic [I2C_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                      wr_valid_q, wr_valid_d;
    logic                      rd_ready_q, rd_ready_d;
    logic                      start_q, start_d;
    logic                      stop_q, stop_d;
    logic                      busy_q, busy_d;

    logic                      start_det, stop_det, last_bit, rd_fetch;
    logic [I2C_DATA_WIDTH-1:0] rx_byte;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        rw_d        = rw_q;
        ack_phase_d = ack_phase_q;
        need_byte_d = need_byte_q;
        sda_d       = sda_q;
        scl_d       = scl_q;
        wr_data_d   = wr_data_q;
        busy_d      = busy_q;
        wr_valid_d  = 1'b0;
        rd_ready_d  = 1'b0;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        rd_fetch    = 1'b0;
        start_det   = sda_fall & scl_lvl;
        stop_det    = sda_rise & scl_lvl;
        last_bit    = (bit_cnt_q == LAST_BIT);
        rx_byte     = {shift_q[I2C_DATA_WIDTH-2:0], sda_lvl};

        case (state_q)
            IDLE: ;
            ADDR: begin
                if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        // General call (all-zero address) is never acknowledged.
                        if (shift_q[I2C_ADDR_WIDTH-1:0] == TARGET_ADDR &&
                            shift_q[I2C_ADDR_WIDTH-1:0] != '0) begin
                            state_d     = ADDR_ACK;
                            busy_d      = 1'b1;
                            rw_d        = sda_lvl;
                            ack_phase_d = 1'b0;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    if (!ack_phase_q) begin
                        sda_d       = 1'b0;
                        ack_phase_d = 1'b1;
                    end else begin
                        sda_d     = 1'b1;
                        bit_cnt_d = '0;
                        if (rw_q == I2C_READ) begin
                            state_d     = RD_BYTE;
                            need_byte_d = 1'b1;
                            rd_fetch    = 1'b1;
                        end else begin
                            state_d = WR_BYTE;
                        end
                    end
                end
            end
            WR_BYTE: begin
                if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        wr_data_d   = rx_byte;
                        wr_valid_d  = 1'b1;
                        state_d     = WR_ACK;
                        ack_phase_d = 1'b0;
                    end
                end
            end
            WR_ACK: begin
                if (scl_fall) begin
                    if (!ack_phase_q) begin
                        sda_d       = ~wr_ready_i;
                        ack_phase_d = 1'b1;
                    end else begin
                        sda_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = sda_q ? IGNORE : WR_BYTE;
                    end
                end
            end
            RD_BYTE: begin
                if (need_byte_q) begin
                    // Fetch on the opening SCL fall, then keep retrying while stretching.
                    if (scl_fall || !scl_q) begin
                        rd_fetch = 1'b1;
                    end
                end else if (!scl_q) begin
                    scl_d = 1'b1;
                end else if (scl_fall) begin
                    if (last_bit) begin
                        sda_d   = 1'b1;
                        state_d = RD_ACK;
                    end else begin
                        sda_d     = shift_q[I2C_DATA_WIDTH-1];
                        shift_d   = {shift_q[I2C_DATA_WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            RD_ACK: begin
                if (scl_rise) begin
                    if (!sda_lvl) begin
                        state_d     = RD_BYTE;
                        need_byte_d = 1'b1;
                    end else begin
                        state_d = IGNORE;
                    end
                end
            end
            IGNORE: ;
            default: state_d = IDLE;
        endcase

        // The byte's MSB goes out with the load; SCL is released one cycle later
        // so SDA has settled before the master can raise SCL.
        if (rd_fetch) begin
            if (rd_valid_i) begin
                shift_d     = {rd_data_i[I2C_DATA_WIDTH-2:0], 1'b0};
                sda_d       = rd_data_i[I2C_DATA_WIDTH-1];
                bit_cnt_d   = '0;
                need_byte_d = 1'b0;
                rd_ready_d  = 1'b1;
            end else begin
                scl_d = 1'b0;
            end
        end

        if (start_det || stop_det) begin
            state_d     = start_det ? ADDR : IDLE;
            start_d     = start_det;
            stop_d      = ~start_det;
            bit_cnt_d   = '0;
            busy_d      = 1'b0;
            sda_d       = 1'b1;
            scl_d       = 1'b1;
            need_byte_d = 1'b0;
            ack_phase_d = 1'b0;
            rd_ready_d  = 1'b0;
            wr_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rw_q        <= 1'b0;
            ack_phase_q <= 1'b0;
            need_byte_q <= 1'b0;
            sda_q       <= 1'b1;
            scl_q       <= 1'b1;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            rd_ready_q  <= 1'b0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rw_q        <= rw_d;
            ack_phase_q <= ack_phase_d;
            need_byte_q <= need_byte_d;
            sda_q       <= sda_d;
            scl_q       <= scl_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            rd_ready_q  <= rd_ready_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_o      = sda_q;
    assign scl_o      = scl_q;
    assign wr_data_o  = wr_data_q;
    assign wr_valid_o = wr_valid_q;
    assign rd_ready_o = rd_ready_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_responder.sv
`default_nettype none
// ============================================================================
// tb_i2c_target_responder : bit-level I2C master model driving the target
// Rev 1.0
// ============================================================================
module tb_i2c_target_responder;
    import i2c_target_pkg::*;

    localparam int Q      = 8;
    localparam int BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_o, sda_o, scl_bus, sda_bus;
    logic [7:0] wr_data_o;
    logic       wr_valid_o;
    logic       wr_ready_i = 1'b1;
    logic [7:0] rd_data_i = 8'h00;
    logic       rd_valid_i = 1'b0;
    logic       rd_ready_o, start_o, stop_o, busy_o;

    int         n_pass = 0, n_total = 0;
    int         n_start = 0, n_stop = 0, n_rdy = 0;
    int         last_stretch = 0, first_stretch = 0;
    logic       rd_en = 1'b1;
    logic       sda_o_prev = 1'b1;
    logic [7:0] mon_exp;
    logic [7:0] src_q[$];
    logic [7:0] exp_wr[$];
    logic [7:0] exp_rd[$];

    assign scl_bus = scl_m & scl_o;
    assign sda_bus = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_target_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .scl_i      (scl_bus),
        .sda_i      (sda_bus),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .wr_data_o  (wr_data_o),
        .wr_valid_o (wr_valid_o),
        .wr_ready_i (wr_ready_i),
        .rd_data_i  (rd_data_i),
        .rd_valid_i (rd_valid_i),
        .rd_ready_o (rd_ready_o),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o)
    );

    // Write-stream scoreboard, read-source feeder and SDA drive-timing monitor.
    always @(negedge clk) begin
        if (wr_valid_o) begin
            n_total++;
            if (exp_wr.size() == 0) begin
                $display("FAIL wr_unexpected: wr_valid_o with data %02h, no byte expected", wr_data_o);
            end else begin
                mon_exp = exp_wr.pop_front();
                if (wr_data_o !== mon_exp)
                    $display("FAIL wr_data: got %02h, expected %02h", wr_data_o, mon_exp);
                else
                    n_pass++;
            end
        end
        if (rd_ready_o) begin
            n_rdy++;
            if (src_q.size() > 0) src_q.delete(0);
        end
        if (start_o) n_start++;
        if (stop_o)  n_stop++;
        if (rst_ni && (sda_o !== sda_o_prev)) begin
            n_total++;
            if ((scl_m & scl_o) !== 1'b0)
                $display("FAIL sda_timing: sda_o changed to %b while SCL=%b, required SCL=0", sda_o, scl_m & scl_o);
            else
                n_pass++;
        end
        sda_o_prev = sda_o;
        rd_valid_i = rd_en && (src_q.size() > 0);
        rd_data_i  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high(output int waited);
        waited = 0;
        while ((scl_m & scl_o) !== 1'b1 && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        if ((scl_m & scl_o) !== 1'b1) begin
            n_total++;
            $display("FAIL scl_timeout: SCL still %b after %0d cycles, required 1", scl_m & scl_o, waited);
        end
    endtask

    task automatic m_bit(input logic b, output logic r);
        int w;
        wait_clks(Q);
        sda_m = b;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_scl_high(w);
        last_stretch = w;
        wait_clks(Q);
        r = sda_m & sda_o;
        wait_clks(Q);
        scl_m = 1'b0;
    endtask

    task automatic m_start;
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clks(2*Q);
        sda_m = 1'b0;
        wait_clks(2*Q);
        scl_m = 1'b0;
    endtask

    task automatic m_rstart;
        int w;
        wait_clks(Q);
        sda_m = 1'b1;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_scl_high(w);
        wait_clks(Q);
        sda_m = 1'b0;
        wait_clks(Q);
        scl_m = 1'b0;
    endtask

    task automatic m_stop;
        int w;
        wait_clks(Q);
        sda_m = 1'b0;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_scl_high(w);
        wait_clks(Q);
        sda_m = 1'b1;
        wait_clks(4*Q);
    endtask

    task automatic m_write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(d[i], r);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read_byte(input logic ack_bit, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r);
            d[i] = r;
            if (i == 7) first_stretch = last_stretch;
        end
        m_bit(ack_bit, r);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        wait_clks(5);
        n_total++;
        if ({scl_o, sda_o} !== 2'b11) $display("FAIL reset_lines: scl_o/sda_o=%b, expected 11", {scl_o, sda_o});
        else n_pass++;
        n_total++;
        if ({wr_valid_o, rd_ready_o, start_o, stop_o, busy_o} !== 5'b0)
            $display("FAIL reset_flags: wr_valid/rd_ready/start/stop/busy=%b, expected 00000",
                     {wr_valid_o, rd_ready_o, start_o, stop_o, busy_o});
        else n_pass++;
        n_total++;
        if (wr_data_o !== 8'h00) $display("FAIL reset_wr_data: got %02h, expected 00", wr_data_o);
        else n_pass++;
        rst_ni = 1'b1;
        wait_clks(20);
        n_total++;
        if (dut.state_q !== IDLE) $display("FAIL reset_state: state %0d, expected IDLE", dut.state_q);
        else n_pass++;
    endtask

    task automatic test_write;
        logic ack;
        int s0, p0;
        s0 = n_start; p0 = n_stop;
        wr_ready_i = 1'b1;
        exp_wr.push_back(8'hA5);
        exp_wr.push_back(8'h3C);
        m_start;
        m_write_byte({7'h22, 1'b0}, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL wr_addr_ack: got %b, expected 0", ack); else n_pass++;
        n_total++;
        if (busy_o !== 1'b1) $display("FAIL wr_busy: got %b, expected 1", busy_o); else n_pass++;
        m_write_byte(8'hA5, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL wr_ack_a5: got %b, expected 0", ack); else n_pass++;
        m_write_byte(8'h3C, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL wr_ack_3c: got %b, expected 0", ack); else n_pass++;
        m_stop;
        n_total++;
        if (n_start - s0 != 1 || n_stop - p0 != 1)
            $display("FAIL wr_start_stop: starts %0d stops %0d, expected 1 1", n_start - s0, n_stop - p0);
        else n_pass++;
        n_total++;
        if (exp_wr.size() != 0) $display("FAIL wr_pending: %0d bytes unseen, expected 0", exp_wr.size());
        else n_pass++;
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL wr_busy_end: got %b, expected 0", busy_o); else n_pass++;
    endtask

    task automatic test_addr_nack;
        logic ack;
        logic [7:0] addrs [2];
        addrs[0] = {7'h23, 1'b0};
        addrs[1] = {7'h00, 1'b0};
        for (int k = 0; k < 2; k++) begin
            m_start;
            m_write_byte(addrs[k], ack);
            n_total++;
            if (ack !== 1'b1) $display("FAIL nack_addr: addr byte %02h ack %b, expected 1", addrs[k], ack);
            else n_pass++;
            n_total++;
            if (busy_o !== 1'b0) $display("FAIL nack_busy: got %b, expected 0", busy_o); else n_pass++;
            m_write_byte(8'h55, ack);
            n_total++;
            if (ack !== 1'b1) $display("FAIL nack_data: ack %b, expected 1", ack); else n_pass++;
            m_stop;
            n_total++;
            if (dut.state_q !== IDLE) $display("FAIL nack_idle: state %0d, expected IDLE", dut.state_q);
            else n_pass++;
        end
    endtask

    task automatic test_read;
        logic ack;
        logic [7:0] d, e;
        int r0;
        r0 = n_rdy;
        rd_en = 1'b1;
        src_q.push_back(8'h5A); exp_rd.push_back(8'h5A);
        src_q.push_back(8'h81); exp_rd.push_back(8'h81);
        m_start;
        m_write_byte({7'h22, I2C_READ}, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rd_addr_ack: got %b, expected 0", ack); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            m_read_byte(k == 1, d);
            e = exp_rd.pop_front();
            n_total++;
            if (d !== e) $display("FAIL rd_data: byte %0d got %02h, expected %02h", k, d, e); else n_pass++;
        end
        n_total++;
        if (dut.state_q !== IGNORE) $display("FAIL rd_nack_state: state %0d, expected IGNORE", dut.state_q);
        else n_pass++;
        m_stop;
        n_total++;
        if (n_rdy - r0 != 2) $display("FAIL rd_ready_count: got %0d, expected 2", n_rdy - r0); else n_pass++;
    endtask

    task automatic test_stretch;
        logic ack;
        logic [7:0] d, e;
        rd_en = 1'b0;
        src_q.push_back(8'h5A); exp_rd.push_back(8'h5A);
        m_start;
        m_write_byte({7'h22, I2C_READ}, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL st_addr_ack: got %b, expected 0", ack); else n_pass++;
        fork
            begin
                wait_clks(250);
                n_total++;
                if (scl_o !== 1'b0) $display("FAIL st_scl_held: scl_o %b mid-stretch, expected 0", scl_o);
                else n_pass++;
                wait_clks(250);
                rd_en = 1'b1;
            end
        join_none
        m_read_byte(1'b1, d);
        e = exp_rd.pop_front();
        n_total++;
        if (d !== e) $display("FAIL st_data: got %02h, expected %02h", d, e); else n_pass++;
        n_total++;
        if (first_stretch < 450 || first_stretch >= BUDGET)
            $display("FAIL st_length: stretched %0d cycles, expected 450..%0d", first_stretch, BUDGET - 1);
        else n_pass++;
        m_stop;
    endtask

    task automatic test_back_to_back;
        logic ack;
        logic [7:0] d, e;
        int s0, p0;
        s0 = n_start; p0 = n_stop;
        exp_wr.push_back(8'h11);
        src_q.push_back(8'h7E); exp_rd.push_back(8'h7E);
        m_start;
        m_write_byte({7'h22, 1'b0}, ack);
        m_write_byte(8'h11, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rs_wr_ack: got %b, expected 0", ack); else n_pass++;
        m_rstart;
        n_total++;
        if (busy_o !== 1'b0) $display("FAIL rs_busy_drop: got %b, expected 0", busy_o); else n_pass++;
        m_write_byte({7'h22, I2C_READ}, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rs_rd_addr_ack: got %b, expected 0", ack); else n_pass++;
        m_read_byte(1'b1, d);
        e = exp_rd.pop_front();
        n_total++;
        if (d !== e) $display("FAIL rs_rd_data: got %02h, expected %02h", d, e); else n_pass++;
        m_stop;
        n_total++;
        if (n_start - s0 != 2 || n_stop - p0 != 1)
            $display("FAIL rs_start_stop: starts %0d stops %0d, expected 2 1", n_start - s0, n_stop - p0);
        else n_pass++;
    endtask

    task automatic test_wr_nack;
        logic ack;
        exp_wr.push_back(8'h12);
        exp_wr.push_back(8'h34);
        m_start;
        m_write_byte({7'h22, 1'b0}, ack);
        wr_ready_i = 1'b1;
        m_write_byte(8'h12, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL wn_first_ack: got %b, expected 0", ack); else n_pass++;
        wr_ready_i = 1'b0;
        m_write_byte(8'h34, ack);
        n_total++;
        if (ack !== 1'b1) $display("FAIL wn_second_nack: got %b, expected 1", ack); else n_pass++;
        m_stop;
        wr_ready_i = 1'b1;
        n_total++;
        if (exp_wr.size() != 0) $display("FAIL wn_pending: %0d bytes unseen, expected 0", exp_wr.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic ack, r;
        int w0, r0;
        src_q.push_back(8'h00);
        m_start;
        m_write_byte({7'h22, I2C_READ}, ack);
        for (int k = 0; k < 3; k++) m_bit(1'b1, r);
        wait_clks(Q);
        n_total++;
        if (sda_o !== 1'b0) $display("FAIL rm_pre_drive: sda_o %b, expected 0", sda_o); else n_pass++;
        #2;
        rst_ni = 1'b0;
        #1;
        n_total++;
        if ({scl_o, sda_o} !== 2'b11) $display("FAIL rm_release: scl_o/sda_o=%b, expected 11", {scl_o, sda_o});
        else n_pass++;
        r0 = n_rdy;
        w0 = exp_wr.size();
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clks(6);
        rst_ni = 1'b1;
        wait_clks(20);
        n_total++;
        if (n_rdy != r0 || busy_o !== 1'b0)
            $display("FAIL rm_quiet: rd_ready pulses %0d busy %b, expected 0 0", n_rdy - r0, busy_o);
        else n_pass++;
        exp_wr.push_back(8'h66);
        m_start;
        m_write_byte({7'h22, 1'b0}, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rm_addr_ack: got %b, expected 0", ack); else n_pass++;
        m_write_byte(8'h66, ack);
        n_total++;
        if (ack !== 1'b0) $display("FAIL rm_data_ack: got %b, expected 0", ack); else n_pass++;
        m_stop;
        n_total++;
        if (exp_wr.size() != w0) $display("FAIL rm_pending: %0d bytes unseen, expected 0", exp_wr.size() - w0);
        else n_pass++;
    endtask

    initial begin
        test_reset;
        test_write;
        test_addr_nack;
        test_read;
        test_stretch;
        test_back_to_back;
        test_wr_nack;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
